// File: rtl/input_conditioner.sv
// Input conditioner for the LED game front-end.
// Two-flop synchronisers followed by independent debounce FSMs for the
// slide-switch vector and the active-low start key. All outputs are
// registered; strobes last exactly one cycle after the committing edge.
module input_conditioner #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switch_raw,
  input  logic             start_raw,
  output logic [WIDTH-1:0] switch,
  output logic             switch_onehot,
  output logic             switch_changed,
  output logic             start,
  output logic             start_pulse
);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } db_state_t;

  // Final count value: the candidate has been seen steady long enough.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // True when exactly one bit of the word is set.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  // ---------------------------------------------------------------------
  // Synchroniser stages
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] switch_sync1;
  logic [WIDTH-1:0] switch_sync2;
  logic             start_sync1;
  logic             start_sync2;

  // Two-flop synchronisers; the key idles high (released) out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      switch_sync1 <= '0;
      switch_sync2 <= '0;
      start_sync1  <= 1'b1;
      start_sync2  <= 1'b1;
    end else begin
      switch_sync1 <= switch_raw;
      switch_sync2 <= switch_sync1;
      start_sync1  <= start_raw;
      start_sync2  <= start_sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Switch-vector debounce channel
  // ---------------------------------------------------------------------
  db_state_t        sw_state;
  db_state_t        sw_state_next;
  logic [WIDTH-1:0] sw_cand;
  logic [CNT_W-1:0] sw_cnt;
  logic             sw_load;
  logic             sw_inc;
  logic             sw_commit;

  // Switch FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_state <= STABLE;
    end else begin
      sw_state <= sw_state_next;
    end
  end

  // Switch FSM next-state and datapath controls; any bit change restarts.
  always_comb begin
    sw_state_next = sw_state;
    sw_load       = 1'b0;
    sw_inc        = 1'b0;
    sw_commit     = 1'b0;
    unique case (sw_state)
      STABLE: begin
        if (switch_sync2 != switch) begin
          sw_load       = 1'b1;
          sw_state_next = SETTLING;
        end
      end
      SETTLING: begin
        if (switch_sync2 != sw_cand) begin
          sw_load = 1'b1;
        end else if (sw_cnt == CNT_LAST) begin
          sw_commit     = 1'b1;
          sw_state_next = STABLE;
        end else begin
          sw_inc = 1'b1;
        end
      end
      default: sw_state_next = STABLE;
    endcase
  end

  // Switch candidate, settle counter, committed word and derived flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_cand        <= '0;
      sw_cnt         <= '0;
      switch         <= '0;
      switch_onehot  <= 1'b0;
      switch_changed <= 1'b0;
    end else begin
      switch_changed <= 1'b0;
      if (sw_load) begin
        sw_cand <= switch_sync2;
        sw_cnt  <= '0;
      end else if (sw_inc) begin
        sw_cnt <= sw_cnt + CNT_W'(1);
      end
      if (sw_commit) begin
        switch         <= sw_cand;
        switch_onehot  <= is_onehot(sw_cand);
        // A bounce that settles back on the old word commits silently.
        switch_changed <= (sw_cand != switch);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Start-key debounce channel
  // ---------------------------------------------------------------------
  db_state_t        key_state;
  db_state_t        key_state_next;
  logic             key_cand;
  logic [CNT_W-1:0] key_cnt;
  logic             key_load;
  logic             key_inc;
  logic             key_commit;

  // Key FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_state <= STABLE;
    end else begin
      key_state <= key_state_next;
    end
  end

  // Key FSM next-state and datapath controls.
  always_comb begin
    key_state_next = key_state;
    key_load       = 1'b0;
    key_inc        = 1'b0;
    key_commit     = 1'b0;
    unique case (key_state)
      STABLE: begin
        if (start_sync2 != start) begin
          key_load       = 1'b1;
          key_state_next = SETTLING;
        end
      end
      SETTLING: begin
        if (start_sync2 != key_cand) begin
          key_load = 1'b1;
        end else if (key_cnt == CNT_LAST) begin
          key_commit     = 1'b1;
          key_state_next = STABLE;
        end else begin
          key_inc = 1'b1;
        end
      end
      default: key_state_next = STABLE;
    endcase
  end

  // Key candidate, settle counter, committed level and press strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_cand    <= 1'b1;
      key_cnt     <= '0;
      start       <= 1'b1;
      start_pulse <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (key_load) begin
        key_cand <= start_sync2;
        key_cnt  <= '0;
      end else if (key_inc) begin
        key_cnt <= key_cnt + CNT_W'(1);
      end
      if (key_commit) begin
        start <= key_cand;
        // Only a committed press (released -> pressed) is announced.
        start_pulse <= start & ~key_cand;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner with a short debounce window.
// The reference model tracks how long each synchronised input has held
// its value and commits once it has been steady long enough.
module tb_input_conditioner;

  localparam int WIDTH = 10;
  localparam int D     = 4;
  localparam int CNT_W = 20;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] switch_raw = '0;
  logic             start_raw = 1'b1;
  logic [WIDTH-1:0] switch;
  logic             switch_onehot;
  logic             switch_changed;
  logic             start;
  logic             start_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_sw_s1, m_sw_s2, m_sw_run_val, m_switch;
  int               m_sw_run_len;
  logic             m_onehot, m_changed;
  logic             m_st_s1, m_st_s2, m_st_run_val, m_start;
  int               m_st_run_len;
  logic             m_pulse;

  logic [WIDTH+3:0] obs, expv;

  always #5 clock = ~clock;

  input_conditioner #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .switch_raw(switch_raw),
    .start_raw(start_raw),
    .switch(switch),
    .switch_onehot(switch_onehot),
    .switch_changed(switch_changed),
    .start(start),
    .start_pulse(start_pulse)
  );

  // Model of one rising edge: a value is committed once the synchronised
  // input has shown it for D+1 consecutive edges and it differs from the output.
  task automatic model_edge(input logic [WIDTH-1:0] sw, input logic st, input logic rst);
    if (rst) begin
      m_sw_s1 = '0; m_sw_s2 = '0; m_sw_run_val = '0; m_sw_run_len = 0;
      m_switch = '0; m_onehot = 1'b0; m_changed = 1'b0;
      m_st_s1 = 1'b1; m_st_s2 = 1'b1; m_st_run_val = 1'b1; m_st_run_len = 0;
      m_start = 1'b1; m_pulse = 1'b0;
    end else begin
      m_changed = 1'b0;
      m_pulse   = 1'b0;
      if (m_sw_s2 == m_sw_run_val) m_sw_run_len++;
      else begin m_sw_run_val = m_sw_s2; m_sw_run_len = 1; end
      if (m_sw_run_len >= D + 1 && m_sw_run_val != m_switch) begin
        m_switch  = m_sw_run_val;
        m_onehot  = ($countones(m_sw_run_val) == 1);
        m_changed = 1'b1;
      end
      if (m_st_s2 == m_st_run_val) m_st_run_len++;
      else begin m_st_run_val = m_st_s2; m_st_run_len = 1; end
      if (m_st_run_len >= D + 1 && m_st_run_val != m_start) begin
        m_start = m_st_run_val;
        m_pulse = (m_st_run_val == 1'b0);
      end
      m_sw_s2 = m_sw_s1; m_sw_s1 = sw;
      m_st_s2 = m_st_s1; m_st_s1 = st;
    end
    expv = {m_switch, m_onehot, m_changed, m_start, m_pulse};
  endtask

  // Drive inputs for one edge, advance the model, sample 1 time unit later.
  task automatic step(input logic [WIDTH-1:0] sw, input logic st, input logic rst);
    switch_raw = sw;
    start_raw  = st;
    reset      = rst;
    @(posedge clock);
    model_edge(sw, st, rst);
    #1;
    obs = {switch, switch_onehot, switch_changed, start, start_pulse};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step('0, 1'b1, 1'b1);
      checks++;
      if (obs !== {{WIDTH{1'b0}}, 4'b0010}) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h, expected %h", i, obs, {{WIDTH{1'b0}}, 4'b0010});
      end
    end
    for (int i = 0; i < 10; i++) begin
      step('0, 1'b1, 1'b0);
      checks++;
      if (obs !== expv || obs !== {{WIDTH{1'b0}}, 4'b0010}) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h, expected %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_switch_commit();
    int first = -1;
    for (int i = 0; i < 12; i++) begin
      step(10'h200, 1'b1, 1'b0);
      if (switch_changed === 1'b1 && first < 0) first = i;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL switch_commit[%0d]: got %h, expected %h", i, obs, expv);
      end
    end
    checks++;
    if (first != D + 2) begin
      errors++;
      $display("FAIL switch_commit_edge: got %0d, expected %0d", first, D + 2);
    end
    checks++;
    if (switch !== 10'h200 || switch_onehot !== 1'b1) begin
      errors++;
      $display("FAIL switch_commit_final: got %h/%b, expected 200/1", switch, switch_onehot);
    end
  endtask

  task automatic test_glitch();
    int strobes = 0;
    for (int i = 0; i < 12; i++) step('0, 1'b1, 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) begin
        step((i < 2) ? 10'h001 : 10'h000, 1'b1, 1'b0);
        if (switch_changed === 1'b1) strobes++;
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL glitch[%0d.%0d]: got %h, expected %h", r, i, obs, expv);
        end
      end
    end
    checks++;
    if (strobes != 0 || switch !== '0) begin
      errors++;
      $display("FAIL glitch_filtered: got %0d strobes switch %h, expected 0 strobes switch 000", strobes, switch);
    end
  endtask

  task automatic test_key();
    int fall = -1, rise = -1, pulses = 0;
    for (int i = 0; i < 10; i++) step('0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step('0, (i < 10) ? 1'b0 : 1'b1, 1'b0);
      if (start === 1'b0 && fall < 0) fall = i;
      if (start === 1'b1 && fall >= 0 && rise < 0) rise = i;
      if (start_pulse === 1'b1) pulses++;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL key[%0d]: got %h, expected %h", i, obs, expv);
      end
    end
    checks++;
    if (fall != D + 2 || rise != 10 + D + 2 || pulses != 1) begin
      errors++;
      $display("FAIL key_timing: got fall %0d rise %0d pulses %0d, expected %0d %0d 1",
               fall, rise, pulses, D + 2, 10 + D + 2);
    end
  endtask

  task automatic test_onehot();
    int strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step(10'h003, 1'b1, 1'b0);
      if (switch_changed === 1'b1) strobes++;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL onehot_a[%0d]: got %h, expected %h", i, obs, expv);
      end
    end
    checks++;
    if (switch !== 10'h003 || switch_onehot !== 1'b0) begin
      errors++;
      $display("FAIL onehot_two_bits: got %h/%b, expected 003/0", switch, switch_onehot);
    end
    for (int i = 0; i < 10; i++) begin
      step(10'h004, 1'b1, 1'b0);
      if (switch_changed === 1'b1) strobes++;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL onehot_b[%0d]: got %h, expected %h", i, obs, expv);
      end
    end
    checks++;
    if (switch !== 10'h004 || switch_onehot !== 1'b1 || strobes != 2) begin
      errors++;
      $display("FAIL onehot_single_bit: got %h/%b strobes %0d, expected 004/1 strobes 2",
               switch, switch_onehot, strobes);
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    for (int i = 0; i < 4; i++) step(10'h010, 1'b1, 1'b0);
    step(10'h010, 1'b1, 1'b1);
    checks++;
    if (obs !== {{WIDTH{1'b0}}, 4'b0010}) begin
      errors++;
      $display("FAIL reset_mid_state: got %h, expected %h", obs, {{WIDTH{1'b0}}, 4'b0010});
    end
    for (int i = 0; i < 10; i++) begin
      step(10'h010, 1'b1, 1'b0);
      if (switch === 10'h010 && first < 0) first = i;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %h, expected %h", i, obs, expv);
      end
    end
    checks++;
    if (first != D + 2) begin
      errors++;
      $display("FAIL reset_mid_latency: got %0d, expected %0d", first, D + 2);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] sw;
    logic st, rst;
    int len;
    for (int s = 0; s < 250; s++) begin
      case ($urandom_range(0, 3))
        0: sw = WIDTH'($urandom);
        1: sw = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        2: sw = switch_raw ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: sw = switch_raw;
      endcase
      st  = ($urandom_range(0, 2) == 0) ? ~start_raw : start_raw;
      len = $urandom_range(1, 2 * D + 2);
      for (int i = 0; i < len; i++) begin
        rst = ($urandom_range(0, 199) == 0);
        step(sw, st, rst);
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL random[%0d.%0d]: got %h, expected %h", s, i, obs, expv);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int both = 0;
    for (int i = 0; i < 12; i++) step('0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(10'h020, 1'b0, 1'b0);
      if (switch_changed === 1'b1 && start_pulse === 1'b1) both = i;
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h, expected %h", i, obs, expv);
      end
    end
    checks++;
    if (both != D + 2) begin
      errors++;
      $display("FAIL simultaneous_strobes: got edge %0d, expected %0d", both, D + 2);
    end
  endtask

  initial begin
    test_reset();
    test_switch_commit();
    test_glitch();
    test_key();
    test_onehot();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Upstream front-end for the LED game status FSM. It synchronises and debounces the 10 slide switches and the active-low start key. It delivers a clean switch word, a clean active-low start level and single-cycle event strobes. The status FSM consumes `switch` and `start` directly in place of the raw board pins.

Parameters:
- WIDTH, 10, number of slide switches.
- DEBOUNCE_CYCLES, 500000, number of clock cycles an input must hold steady before it is committed (10 ms at 50 MHz). Legal range 2 to 2^20.
- CNT_W, 20, width of each settle counter. Must hold DEBOUNCE_CYCLES-1.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- switch_raw  input  WIDTH  asynchronous board switches.
- start_raw  input  1  asynchronous start key, active-low (0 = pressed).
- switch  output  WIDTH  debounced switch word.
- switch_onehot  output  1  registered; 1 when exactly one bit of `switch` is set.
- switch_changed  output  1  one-cycle strobe when `switch` takes a new value.
- start  output  1  debounced start key level, active-low.
- start_pulse  output  1  one-cycle strobe on a debounced press (start 1->0).

Behaviour:
- Reset values, applied at any rising edge with reset=1 (including mid-settle):
  - sync stages: 0 for switch, 1 for key.
  - switch=0, switch_onehot=0, switch_changed=0.
  - start=1, start_pulse=0.
  - both FSMs return to STABLE; counters and candidates cleared (key candidate=1).
- Synchroniser: two flops per input (sync1 then sync2). The debounce logic only sees sync2.
- Switch and key have two independent debounce FSMs and separate counters. The whole switch vector shares one FSM; any bit change restarts it.
- Debounce FSM, per channel:
  - STABLE: if sync2 != committed output, set candidate <= sync2, count <= 0, go to SETTLING. Otherwise stay.
  - SETTLING, sync2 != candidate: candidate <= sync2, count <= 0, stay (restart).
  - SETTLING, sync2 == candidate and count == DEBOUNCE_CYCLES-1: commit (output <= candidate), go to STABLE.
  - SETTLING, otherwise: count <= count+1.
- Commit rules:
  - Switch channel commit: set switch_onehot <= (candidate has exactly one bit set) in the same edge.
  - switch_changed = 1 for exactly the cycle after a commit where candidate != old switch.
  - A bounce that returns to the old value commits without a strobe.
  - Key channel: start_pulse = 1 for one cycle only when committing 1->0. A release (0->1) produces no pulse.
- Latency: raw held stable from before edge 0 gives sync2 updated at edge 1 and SETTLING entered at edge 2. Output and strobe are asserted after edge DEBOUNCE_CYCLES+2.
- Glitches shorter than DEBOUNCE_CYCLES cycles (post-sync) never reach the outputs.
- Simultaneous switch and key commits are independent; both strobes may assert in the same cycle.
- Counter never wraps; it is bounded by the compare at DEBOUNCE_CYCLES-1.
- No combinational path from raw inputs to any output; all outputs are registered.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset held 3 cycles, then released with switch_raw=0 and start_raw=1 -> switch=0, start=1, all strobes 0, no change thereafter.
2. switch_raw 0 -> 0x200 held -> switch=0x200, switch_onehot=1, switch_changed high exactly one cycle after edge 6 (D+2); switch=0 before that edge.
3. switch_raw toggles 0x001 for 2 cycles then returns to 0, repeated 5 times -> switch stays 0, switch_changed never asserts.
4. start_raw pressed (0) for 10 cycles then released -> start falls after edge 6, start_pulse high one cycle. start returns to 1 six edges after release, with no pulse.
5. switch_raw=0x003 committed -> switch_onehot=0. Then 0x004 -> switch_onehot=1, with a switch_changed pulse at each commit.
6. Reset asserted midway through a SETTLING run with switch_raw=0x010 -> outputs are at reset values the next cycle. After release, commit occurs a full D+2 edges later, not earlier.
